phy_rx: RTL and testbench

Receive-side physical-layer block: converts the single 8-bit byte stream emitted by the transmit PHY back into four parallel byte lanes. Acquires lock on a run of COM (0xBC) symbols, uses COM to align the lane pointer, and distributes subsequent data bytes round-robin to lanes 0..3. A complete 4-byte word is presented on all lanes simultaneously. Sits directly after the serial link, feeding the lane consumers that mirror the transmitter's inputs.

---
 rtl/phy_pkg.sv | 18 +
 rtl/phy_rx_lock.sv | 81 ++++++++
 rtl/phy_rx.sv | 131 +++++++++++++
 tb/tb_phy_rx.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions used by the transmit and receive PHY blocks:
// the idle/alignment symbol, lane count, link state encoding and a
// saturating byte increment helper.
package phy_pkg;

    localparam logic [7:0] COM_BYTE_DEFAULT = 8'hBC;
    localparam int         NUM_LANES        = 4;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_ACTIVE = 1'b1
    } phy_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/phy_rx_lock.sv
// Link lock tracker for the receive PHY.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SEARCH | counting consecutive valid COM bytes; no data delivered
//   ST_ACTIVE | locked; data flows; idle cycles counted towards lock loss
//
// locked follows the state; lock_lost pulses for one cycle after the edge
// on which the idle run reaches LOSS_CYCLES.
module phy_rx_lock
    import phy_pkg::*;
#(
    parameter logic [7:0] COM_BYTE    = COM_BYTE_DEFAULT,
    parameter int         LOCK_COUNT  = 4,
    parameter int         LOSS_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       locked,
    output logic       lock_lost
);

    localparam logic [3:0] RUN_LAST  = 4'(LOCK_COUNT - 1);
    localparam logic [7:0] IDLE_LAST = 8'(LOSS_CYCLES - 1);

    phy_state_e state_q;
    logic [3:0] run_q;
    logic [7:0] idle_q;
    logic       locked_q;
    logic       lock_lost_q;

    // Lock FSM: COM-run counting in SEARCH, idle-run counting in ACTIVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            run_q       <= 4'd0;
            idle_q      <= 8'd0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lock_lost_q <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    if (valid_in) begin
                        if (data_in == COM_BYTE) begin
                            if (run_q == RUN_LAST) begin
                                state_q  <= ST_ACTIVE;
                                locked_q <= 1'b1;
                                run_q    <= 4'd0;
                                idle_q   <= 8'd0;
                            end else begin
                                run_q <= run_q + 4'd1;
                            end
                        end else begin
                            run_q <= 4'd0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (valid_in) begin
                        idle_q <= 8'd0;
                    end else if (idle_q == IDLE_LAST) begin
                        state_q     <= ST_SEARCH;
                        locked_q    <= 1'b0;
                        lock_lost_q <= 1'b1;
                        idle_q      <= 8'd0;
                        run_q       <= 4'd0;
                    end else if (idle_q != 8'hFF) begin
                        idle_q <= idle_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: rtl/phy_rx.sv
// Receive PHY: reassembles the serial byte stream into four parallel lanes.
// COM bytes align the lane pointer and are never delivered as data.
// Optional feature macro PHY_RX_ERR_CNT_EN adds an 8-bit saturating
// err_count of alignment errors plus lock-loss events.
module phy_rx
    import phy_pkg::*;
#(
    parameter logic [7:0] COM_BYTE    = COM_BYTE_DEFAULT,
    parameter int         LOCK_COUNT  = 4,
    parameter int         LOSS_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] Out0,
    output logic [7:0] Out1,
    output logic [7:0] Out2,
    output logic [7:0] Out3,
    output logic       valid0,
    output logic       valid1,
    output logic       valid2,
    output logic       valid3,
    output logic       locked,
    output logic       align_err
`ifdef PHY_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    logic                          lock_lost;
    logic [1:0]                    ptr_q, ptr_d;
    logic [NUM_LANES-2:0][7:0]     hold_q, hold_d;
    logic [NUM_LANES-1:0][7:0]     out_q, out_d;
    logic                          valid_q, valid_d;
    logic                          align_err_q, align_err_d;

    phy_rx_lock #(
        .COM_BYTE    (COM_BYTE),
        .LOCK_COUNT  (LOCK_COUNT),
        .LOSS_CYCLES (LOSS_CYCLES)
    ) u_lock (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .locked    (locked),
        .lock_lost (lock_lost)
    );

    // Lane steering: out of lock the pointer is parked at 0, which both
    // discards any partial word on lock loss and aligns the first word.
    always_comb begin
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        out_d       = out_q;
        valid_d     = 1'b0;
        align_err_d = 1'b0;
        if (!locked) begin
            ptr_d = 2'd0;
        end else if (valid_in) begin
            if (data_in == COM_BYTE) begin
                if (ptr_q != 2'd0) begin
                    align_err_d = 1'b1;
                    ptr_d       = 2'd0;
                end
            end else begin
                case (ptr_q)
                    2'd0: hold_d[0] = data_in;
                    2'd1: hold_d[1] = data_in;
                    2'd2: hold_d[2] = data_in;
                    default: begin
                        out_d   = {data_in, hold_q[2], hold_q[1], hold_q[0]};
                        valid_d = 1'b1;
                    end
                endcase
                ptr_d = ptr_q + 2'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= 2'd0;
            hold_q      <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            align_err_q <= align_err_d;
        end
    end

    assign Out0      = out_q[0];
    assign Out1      = out_q[1];
    assign Out2      = out_q[2];
    assign Out3      = out_q[3];
    assign valid0    = valid_q;
    assign valid1    = valid_q;
    assign valid2    = valid_q;
    assign valid3    = valid_q;
    assign align_err = align_err_q;

`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // Error events arrive as registered pulses, so the count trails by a cycle.
    always_comb begin
        err_d = err_q;
        if (align_err_q || lock_lost) err_d = sat_inc8(err_q);
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) err_q <= 8'd0;
        else       err_q <= err_d;
    end

    assign err_count = err_q;
`else
    logic unused_lock_lost;
    assign unused_lock_lost = lock_lost;
`endif

endmodule

// File: tb/tb_phy_rx.sv
// Testbench for phy_rx: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the receive PHY.
module tb_phy_rx;

    localparam logic [7:0] COM    = 8'hBC;
    localparam int         LOCK_N = 4;
    localparam int         LOSS_N = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] Out0, Out1, Out2, Out3;
    logic       valid0, valid1, valid2, valid3;
    logic       locked, align_err;
`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int failures = 0;

    // behavioural model state
    bit         m_locked;
    int         m_run;
    int         m_idle;
    logic [7:0] m_part[$];
    logic [7:0] m_out[4];
    bit         m_valid;
    bit         m_aerr;
    int         m_err;

    phy_rx dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .Out0      (Out0),
        .Out1      (Out1),
        .Out2      (Out2),
        .Out3      (Out3),
        .valid0    (valid0),
        .valid1    (valid1),
        .valid2    (valid2),
        .valid3    (valid3),
        .locked    (locked),
        .align_err (align_err)
`ifdef PHY_RX_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] act_vec();
        return {Out3, Out2, Out1, Out0, valid3, valid2, valid1, valid0, locked, align_err};
    endfunction

    function automatic logic [37:0] exp_vec();
        return {m_out[3], m_out[2], m_out[1], m_out[0],
                {4{m_valid}}, m_locked, m_aerr};
    endfunction

    // Drive one cycle of input, wait past the edge, advance the model.
    task automatic step(input bit r, input bit v, input logic [7:0] d);
        reset    = r;
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_locked = 0; m_run = 0; m_idle = 0; m_part.delete();
            for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
            m_valid = 0; m_aerr = 0; m_err = 0;
        end else begin
            m_valid = 0;
            m_aerr  = 0;
            if (!m_locked) begin
                if (v) begin
                    if (d == COM) begin
                        m_run++;
                        if (m_run == LOCK_N) begin
                            m_locked = 1; m_run = 0; m_idle = 0; m_part.delete();
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            end else if (v) begin
                m_idle = 0;
                if (d == COM) begin
                    if (m_part.size() != 0) begin
                        m_aerr = 1; m_err++; m_part.delete();
                    end
                end else begin
                    m_part.push_back(d);
                    if (m_part.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_out[i] = m_part[i];
                        m_valid = 1;
                        m_part.delete();
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == LOSS_N) begin
                    m_locked = 0; m_run = 0; m_idle = 0; m_part.delete(); m_err++;
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic lock_link();
        for (int i = 0; i < LOCK_N; i++) step(0, 1, COM);
    endtask

    task automatic test_reset();
        step(1, 0, 8'h00);
        step(1, 1, COM);
        checks++;
        if (act_vec() !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", act_vec(), 38'd0);
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < LOCK_N; i++) begin
            step(0, 1, COM);
            checks++;
            if (locked !== (i == LOCK_N - 1)) begin
                failures++;
                $display("FAIL lock_com%0d: locked=%b expected %b", i, locked, (i == LOCK_N - 1));
            end
        end
        checks++;
        if ({Out3, Out2, Out1, Out0, valid0, align_err} !== 34'd0) begin
            failures++;
            $display("FAIL lock_no_data: got %h expected 0", {Out3, Out2, Out1, Out0, valid0, align_err});
        end
    endtask

    task automatic test_word();
        logic [7:0] w[4];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, w[i]);
            checks++;
            if (valid0 !== 1'b0) begin
                failures++;
                $display("FAIL word_early_valid%0d: valid0=%b expected 0", i, valid0);
            end
        end
        step(0, 1, w[3]);
        checks++;
        if ({Out3, Out2, Out1, Out0, valid3, valid2, valid1, valid0} !== {32'h44332211, 4'hF}) begin
            failures++;
            $display("FAIL word_out: got %h expected %h",
                     {Out3, Out2, Out1, Out0, valid3, valid2, valid1, valid0}, {32'h44332211, 4'hF});
        end
        step(0, 0, 8'h00);
        checks++;
        if ({Out3, Out2, Out1, Out0, valid0} !== {32'h44332211, 1'b0}) begin
            failures++;
            $display("FAIL word_hold: got %h expected %h", {Out3, Out2, Out1, Out0, valid0}, {32'h44332211, 1'b0});
        end
    endtask

    task automatic test_align();
        step(0, 1, 8'h01);
        step(0, 1, 8'h02);
        step(0, 1, COM);
        checks++;
        if ({align_err, valid0} !== 2'b10) begin
            failures++;
            $display("FAIL align_pulse: got %b expected 10", {align_err, valid0});
        end
        step(0, 1, 8'hA0);
        checks++;
        if (align_err !== 1'b0) begin
            failures++;
            $display("FAIL align_one_cycle: align_err=%b expected 0", align_err);
        end
        step(0, 1, 8'hA1);
        step(0, 1, 8'hA2);
        step(0, 1, 8'hA3);
        checks++;
        if ({Out3, Out2, Out1, Out0, valid0} !== {32'hA3A2A1A0, 1'b1}) begin
            failures++;
            $display("FAIL align_next_word: got %h expected %h", {Out3, Out2, Out1, Out0, valid0}, {32'hA3A2A1A0, 1'b1});
        end
    endtask

    task automatic test_run_restart();
        step(1, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, COM);
        step(0, 1, 8'h55);
        for (int i = 0; i < 3; i++) step(0, 1, COM);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL restart_early_lock: locked=%b expected 0", locked);
        end
        step(0, 1, COM);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL restart_lock: locked=%b expected 1", locked);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < LOSS_N - 1; i++) step(0, 0, 8'h00);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL idle15_locked: locked=%b expected 1", locked);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 8'h10 + 8'(i));
        checks++;
        if ({Out3, Out2, Out1, Out0, valid0} !== {32'h13121110, 1'b1}) begin
            failures++;
            $display("FAIL idle_word: got %h expected %h", {Out3, Out2, Out1, Out0, valid0}, {32'h13121110, 1'b1});
        end
        for (int i = 0; i < LOSS_N - 1; i++) step(0, 0, 8'h00);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL idle15b_locked: locked=%b expected 1", locked);
        end
        step(0, 0, 8'h00);
        checks++;
        if ({locked, Out3, Out2, Out1, Out0} !== {1'b0, 32'h13121110}) begin
            failures++;
            $display("FAIL idle16_drop: got %h expected %h", {locked, Out3, Out2, Out1, Out0}, {1'b0, 32'h13121110});
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h60 + 8'(i));
            checks++;
            if ({valid0, locked} !== 2'b00) begin
                failures++;
                $display("FAIL unlocked_ignore%0d: got %b expected 00", i, {valid0, locked});
            end
        end
        lock_link();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL relock: locked=%b expected 1", locked);
        end
    endtask

    task automatic test_mid_reset();
        step(0, 1, 8'h21);
        step(0, 1, 8'h22);
        step(1, 1, 8'h23);
        checks++;
        if (act_vec() !== 38'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h expected 0", act_vec());
        end
        step(0, 1, 8'h23);
        step(0, 1, 8'h24);
        checks++;
        if ({valid0, locked} !== 2'b00) begin
            failures++;
            $display("FAIL midreset_relock_needed: got %b expected 00", {valid0, locked});
        end
        lock_link();
        for (int i = 0; i < 4; i++) step(0, 1, 8'h30 + 8'(i));
        checks++;
        if ({Out3, Out2, Out1, Out0, valid0} !== {32'h33323130, 1'b1}) begin
            failures++;
            $display("FAIL midreset_word: got %h expected %h", {Out3, Out2, Out1, Out0, valid0}, {32'h33323130, 1'b1});
        end
    endtask

    task automatic test_random();
        int seg, len;
        logic [7:0] b;
        for (int s = 0; s < 400; s++) begin
            seg = $urandom_range(0, 9);
            if ($urandom_range(0, 39) == 0) begin
                step(1, $urandom_range(0, 1), 8'($urandom));
                checks++;
                if (act_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL rand_reset seg%0d: got %h expected %h", s, act_vec(), exp_vec());
                end
            end
            len = (seg < 2) ? $urandom_range(4, 6) : (seg < 8) ? $urandom_range(1, 12) : $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                if (seg < 2) begin
                    step(0, 1, COM);
                end else if (seg < 8) begin
                    b = ($urandom_range(0, 19) == 0) ? COM : 8'($urandom);
                    step(0, ($urandom_range(0, 9) != 0), b);
                end else begin
                    step(0, 0, 8'($urandom));
                end
                checks++;
                if (act_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL rand_cycle seg%0d k%0d: got %h expected %h", s, k, act_vec(), exp_vec());
                end
            end
        end
    endtask

`ifdef PHY_RX_ERR_CNT_EN
    task automatic test_err_cnt();
        step(1, 0, 8'h00);
        lock_link();
        checks++;
        if (err_count !== 8'd0) begin
            failures++;
            $display("FAIL errcnt_zero: got %h expected 00", err_count);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h42);
            step(0, 1, COM);
        end
        step(0, 1, COM);
        checks++;
        if (err_count !== 8'(m_err)) begin
            failures++;
            $display("FAIL errcnt_align: got %h expected %h", err_count, 8'(m_err));
        end
        for (int i = 0; i < LOSS_N + 2; i++) step(0, 0, 8'h00);
        checks++;
        if (err_count !== 8'(m_err)) begin
            failures++;
            $display("FAIL errcnt_loss: got %h expected %h", err_count, 8'(m_err));
        end
        lock_link();
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 8'h42);
            step(0, 1, COM);
        end
        step(0, 1, COM);
        checks++;
        if (err_count !== 8'hFF) begin
            failures++;
            $display("FAIL errcnt_sat: got %h expected ff", err_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_word();
        test_align();
        test_run_restart();
        test_idle();
        test_mid_reset();
        test_random();
`ifdef PHY_RX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
